// File: rtl/ibex_pmp_csr_regs_pkg.sv
// Types and constants shared by the PMP CSR register block.
//   pmp_cfg_mode_e / pmp_cfg_t : one region's configuration as seen by the PMP checker
//   pmp_mseccfg_t              : Smepmp machine security configuration (mml, mmwp, rlb)
//   CSR_* constants            : CSR addresses decoded by the register block
//   MSECCFG_*_BIT              : bit positions of the mseccfg fields in CSR data
//   pmp_cfg_to_byte            : packs a cfg into its architectural 8-bit CSR layout
package ibex_pmp_csr_regs_pkg;

   typedef enum logic [1:0] {
      PMP_MODE_OFF   = 2'b00,
      PMP_MODE_TOR   = 2'b01,
      PMP_MODE_NA4   = 2'b10,
      PMP_MODE_NAPOT = 2'b11
   } pmp_cfg_mode_e;

   typedef struct packed {
      logic          lock;
      pmp_cfg_mode_e mode;
      logic          exec;
      logic          write;
      logic          read;
   } pmp_cfg_t;

   typedef struct packed {
      logic rlb;
      logic mmwp;
      logic mml;
   } pmp_mseccfg_t;

   localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
   localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;
   localparam logic [11:0] CSR_MSECCFG  = 12'h747;
   localparam logic [11:0] CSR_MSECCFGH = 12'h757;

   localparam int unsigned MSECCFG_MML_BIT  = 0;
   localparam int unsigned MSECCFG_MMWP_BIT = 1;
   localparam int unsigned MSECCFG_RLB_BIT  = 2;

   // Bits 6:5 of a cfg byte are reserved and always read as zero.
   function automatic logic [7:0] pmp_cfg_to_byte(pmp_cfg_t c);
      return {c.lock, 2'b00, c.mode, c.exec, c.write, c.read};
   endfunction

endpackage

// File: rtl/ibex_pmp_csr_regs_if.sv
// CSR access bus between the CSR file and the PMP register block.
//   csr_we_i         : write strobe, one cycle per write
//   csr_addr_i       : CSR address, shared by the read and write paths
//   csr_wdata_i      : write data
//   csr_rdata_o      : combinational read data of the legalised state at csr_addr_i
//   csr_wr_ignored_o : one-cycle pulse after a write that a lock or Smepmp rule cut short
// Handshake: a write is accepted on every rising clock edge where csr_we_i is 1; there
// is no ready signal and no backpressure, so the master may issue one write per cycle.
// Reads carry no strobe at all: csr_rdata_o simply follows csr_addr_i.
interface ibex_pmp_csr_regs_if;
   logic        csr_we_i;
   logic [11:0] csr_addr_i;
   logic [31:0] csr_wdata_i;
   logic [31:0] csr_rdata_o;
   logic        csr_wr_ignored_o;

   modport master (
      output csr_we_i, csr_addr_i, csr_wdata_i,
      input  csr_rdata_o, csr_wr_ignored_o
   );

   modport slave (
      input  csr_we_i, csr_addr_i, csr_wdata_i,
      output csr_rdata_o, csr_wr_ignored_o
   );
endinterface

// File: rtl/ibex_pmp_cfg_legalize.sv
// Combinational legalisation of one pmpcfg byte write.
//   wdata_i     : byte written to this region
//   cfg_old_i   : currently stored cfg of the region
//   mml_i/rlb_i : current mseccfg bits
//   cfg_new_o   : WARL-legalised value of the written byte
//   discard_o   : the write must not update the region (lock or Smepmp rule)
//   ignored_o   : discard_o and the stored value differs from what was written
module ibex_pmp_cfg_legalize
   import ibex_pmp_csr_regs_pkg::*;
#(
   parameter int unsigned PMPGranularity = 0
) (
   input  logic [7:0] wdata_i,
   input  pmp_cfg_t   cfg_old_i,
   input  logic       mml_i,
   input  logic       rlb_i,
   output pmp_cfg_t   cfg_new_o,
   output logic       discard_o,
   output logic       ignored_o
);

   logic eff_lock;
   logic smepmp_deny;

   always_comb begin
      cfg_new_o.read  = wdata_i[0];
      // Without MML the R=0,W=1 combination is reserved, so W collapses to W&R.
      cfg_new_o.write = mml_i ? wdata_i[1] : (wdata_i[1] & wdata_i[0]);
      cfg_new_o.exec  = wdata_i[2];
      cfg_new_o.mode  = pmp_cfg_mode_e'(wdata_i[4:3]);
      // NA4 cannot be expressed once the granule exceeds four bytes.
      if ((PMPGranularity >= 1) && (cfg_new_o.mode == PMP_MODE_NA4)) begin
         cfg_new_o.mode = PMP_MODE_OFF;
      end
      cfg_new_o.lock  = wdata_i[7];

      eff_lock    = cfg_old_i.lock & ~rlb_i;
      // Under MML a new locked rule that is executable or shared-write-only is refused
      // unless rule-locking bypass is active.
      smepmp_deny = mml_i & ~rlb_i & wdata_i[7] & (wdata_i[2] | (~wdata_i[0] & wdata_i[1]));
      discard_o   = eff_lock | smepmp_deny;
      ignored_o   = discard_o & (cfg_new_o != cfg_old_i);
   end

endmodule

// File: rtl/ibex_pmp_csr_regs.sv
// Architectural PMP CSR state: pmpcfg0-3, pmpaddr0-15 and mseccfg, legalised on write.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   bus                  : CSR read/write bus (slave side)
//   csr_pmp_cfg_o        : per-region cfg, straight from flops
//   csr_pmp_addr_o       : per-region {pmpaddr, 2'b00}, raw stored value
//   csr_pmp_mseccfg_o    : mseccfg straight from flops
module ibex_pmp_csr_regs
   import ibex_pmp_csr_regs_pkg::*;
#(
   parameter int unsigned PMPGranularity = 0,
   parameter int unsigned PMPNumRegions  = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   ibex_pmp_csr_regs_if.slave    bus,
   output pmp_cfg_t              csr_pmp_cfg_o     [PMPNumRegions],
   output logic [33:0]           csr_pmp_addr_o    [PMPNumRegions],
   output pmp_mseccfg_t          csr_pmp_mseccfg_o
);

   // Read-back masks for pmpaddr; the stored bits are never altered by them.
   localparam logic [31:0] NapotOnes   = (PMPGranularity >= 2) ?
                                         ((32'd1 << (PMPGranularity - 1)) - 32'd1) : 32'd0;
   localparam logic [31:0] OffTorZeros = (PMPGranularity >= 1) ?
                                         ((32'd1 << PMPGranularity) - 32'd1) : 32'd0;

   pmp_cfg_t                 cfg_q     [PMPNumRegions];
   pmp_cfg_t                 cfg_d     [PMPNumRegions];
   pmp_cfg_t                 cfg_legal [PMPNumRegions];
   logic [31:0]              addr_q    [PMPNumRegions];
   logic [31:0]              addr_d    [PMPNumRegions];
   logic [PMPNumRegions-1:0] cfg_discard;
   logic [PMPNumRegions-1:0] cfg_ign;
   logic [PMPNumRegions-1:0] lock_bits;
   logic [PMPNumRegions-1:0] eff_lock;
   logic [PMPNumRegions-1:0] addr_lock;
   logic [PMPNumRegions:0]   tor_lock;
   logic                     any_lock;
   pmp_mseccfg_t             mseccfg_q, mseccfg_d;
   logic                     wr_ignored_q, wr_ignored_d;
   logic [31:0]              rdata;

   for (genvar i = 0; i < PMPNumRegions; i++) begin : g_region
      ibex_pmp_cfg_legalize #(
         .PMPGranularity (PMPGranularity)
      ) u_legalize (
         .wdata_i   (bus.csr_wdata_i[8*(i%4) +: 8]),
         .cfg_old_i (cfg_q[i]),
         .mml_i     (mseccfg_q.mml),
         .rlb_i     (mseccfg_q.rlb),
         .cfg_new_o (cfg_legal[i]),
         .discard_o (cfg_discard[i]),
         .ignored_o (cfg_ign[i])
      );

      assign lock_bits[i] = cfg_q[i].lock;
      assign eff_lock[i]  = cfg_q[i].lock & ~mseccfg_q.rlb;
      assign tor_lock[i]  = eff_lock[i] & (cfg_q[i].mode == PMP_MODE_TOR);
      // A locked TOR region also freezes the address below it, its base.
      assign addr_lock[i] = eff_lock[i] | tor_lock[i+1];

      assign csr_pmp_cfg_o[i]  = cfg_q[i];
      assign csr_pmp_addr_o[i] = {addr_q[i], 2'b00};
   end

   assign tor_lock[PMPNumRegions] = 1'b0;
   assign any_lock                = |lock_bits;

   always_comb begin
      cfg_d        = cfg_q;
      addr_d       = addr_q;
      mseccfg_d    = mseccfg_q;
      wr_ignored_d = 1'b0;
      if (bus.csr_we_i) begin
         for (int i = 0; i < PMPNumRegions; i++) begin
            if (bus.csr_addr_i == CSR_PMPCFG0 + 12'(i / 4)) begin
               if (!cfg_discard[i]) cfg_d[i] = cfg_legal[i];
               if (cfg_ign[i]) wr_ignored_d = 1'b1;
            end
            if (bus.csr_addr_i == CSR_PMPADDR0 + 12'(i)) begin
               if (!addr_lock[i]) begin
                  addr_d[i] = bus.csr_wdata_i;
               end else if (bus.csr_wdata_i != addr_q[i]) begin
                  wr_ignored_d = 1'b1;
               end
            end
         end
         if (bus.csr_addr_i == CSR_MSECCFG) begin
            mseccfg_d.mml  = mseccfg_q.mml  | bus.csr_wdata_i[MSECCFG_MML_BIT];
            mseccfg_d.mmwp = mseccfg_q.mmwp | bus.csr_wdata_i[MSECCFG_MMWP_BIT];
            // Once rlb drops while a region is locked it stays off until reset.
            mseccfg_d.rlb  = bus.csr_wdata_i[MSECCFG_RLB_BIT] & (mseccfg_q.rlb | ~any_lock);
            if (mseccfg_d != pmp_mseccfg_t'(bus.csr_wdata_i[2:0])) wr_ignored_d = 1'b1;
         end
      end
   end

   always_comb begin
      rdata = 32'd0;
      for (int i = 0; i < PMPNumRegions; i++) begin
         if (bus.csr_addr_i == CSR_PMPCFG0 + 12'(i / 4)) begin
            rdata[8*(i%4) +: 8] = pmp_cfg_to_byte(cfg_q[i]);
         end
         if (bus.csr_addr_i == CSR_PMPADDR0 + 12'(i)) begin
            if (cfg_q[i].mode == PMP_MODE_NAPOT) begin
               rdata = addr_q[i] | NapotOnes;
            end else if (cfg_q[i].mode == PMP_MODE_NA4) begin
               rdata = addr_q[i];
            end else begin
               rdata = addr_q[i] & ~OffTorZeros;
            end
         end
      end
      if (bus.csr_addr_i == CSR_MSECCFG) rdata = {29'd0, mseccfg_q};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < PMPNumRegions; i++) begin
            cfg_q[i]  <= '0;
            addr_q[i] <= '0;
         end
         mseccfg_q    <= '0;
         wr_ignored_q <= 1'b0;
      end else begin
         cfg_q        <= cfg_d;
         addr_q       <= addr_d;
         mseccfg_q    <= mseccfg_d;
         wr_ignored_q <= wr_ignored_d;
      end
   end

   assign bus.csr_rdata_o      = rdata;
   assign bus.csr_wr_ignored_o = wr_ignored_q;
   assign csr_pmp_mseccfg_o    = mseccfg_q;

endmodule

// File: tb/tb_ibex_pmp_csr_regs.sv
// Bench for ibex_pmp_csr_regs with 6 regions and a 16-byte granule (G=2).
module tb_ibex_pmp_csr_regs;
   import ibex_pmp_csr_regs_pkg::*;

   localparam int G = 2;
   localparam int N = 6;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ibex_pmp_csr_regs_if bus_if();
   pmp_cfg_t     cfg_o  [N];
   logic [33:0]  addr_o [N];
   pmp_mseccfg_t msec_o;

   ibex_pmp_csr_regs #(
      .PMPGranularity (G),
      .PMPNumRegions  (N)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .bus               (bus_if),
      .csr_pmp_cfg_o     (cfg_o),
      .csr_pmp_addr_o    (addr_o),
      .csr_pmp_mseccfg_o (msec_o)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] cfg_byte(input pmp_cfg_t c);
      return {c.lock, 2'b00, c.mode, c.exec, c.write, c.read};
   endfunction

   // ---------------- reference model ----------------
   // Architectural state as plain bytes/words, updated by the rules of each CSR.
   logic [7:0]  m_cfg  [16];
   logic [31:0] m_addr [16];
   logic        m_mml, m_mmwp, m_rlb, m_ign;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_cfg[i]  = 8'h00;
         m_addr[i] = 32'h0;
      end
      m_mml = 1'b0; m_mmwp = 1'b0; m_rlb = 1'b0; m_ign = 1'b0;
   endtask

   function automatic logic [31:0] model_read(input logic [11:0] a);
      logic [31:0] v;
      int r;
      v = 32'h0;
      if (a >= 12'h3A0 && a <= 12'h3A3) begin
         for (int k = 0; k < 4; k++) begin
            r = int'(a - 12'h3A0) * 4 + k;
            if (r < N) v = v | (32'(m_cfg[r]) << (8 * k));
         end
      end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
         r = int'(a - 12'h3B0);
         if (r < N) begin
            v = m_addr[r];
            case (m_cfg[r][4:3])
               2'd3:       if (G >= 2) v = v | ((32'd1 << (G - 1)) - 32'd1);
               2'd0, 2'd1: if (G >= 1) v = v & ~((32'd1 << G) - 32'd1);
               default:    ;
            endcase
         end
      end else if (a == 12'h747) begin
         v = {29'd0, m_rlb, m_mmwp, m_mml};
      end
      return v;
   endfunction

   task automatic model_write(input logic [11:0] a, input logic [31:0] w);
      logic       any_lock, locked, deny, rlb_new;
      logic [7:0] b, nb;
      int         r;
      m_ign    = 1'b0;
      any_lock = 1'b0;
      for (int i = 0; i < N; i++) if (m_cfg[i][7]) any_lock = 1'b1;
      if (a >= 12'h3A0 && a <= 12'h3A3) begin
         for (int k = 0; k < 4; k++) begin
            r = int'(a - 12'h3A0) * 4 + k;
            if (r < N) begin
               b  = w[8*k +: 8];
               nb = b & 8'h9F;
               if (!m_mml && !b[0]) nb[1] = 1'b0;
               if (G >= 1 && nb[4:3] == 2'd2) nb[4:3] = 2'd0;
               locked = m_cfg[r][7] && !m_rlb;
               deny   = m_mml && !m_rlb && b[7] && (b[2] || (!b[0] && b[1]));
               if (locked || deny) begin
                  if (nb != m_cfg[r]) m_ign = 1'b1;
               end else begin
                  m_cfg[r] = nb;
               end
            end
         end
      end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
         r = int'(a - 12'h3B0);
         if (r < N) begin
            locked = (m_cfg[r][7] && !m_rlb) ||
                     ((r + 1 < N) && m_cfg[r+1][7] && !m_rlb && m_cfg[r+1][4:3] == 2'd1);
            if (locked) begin
               if (w != m_addr[r]) m_ign = 1'b1;
            end else begin
               m_addr[r] = w;
            end
         end
      end else if (a == 12'h747) begin
         rlb_new = w[2] && (m_rlb || !any_lock);
         if (((m_mml | w[0]) != w[0]) || ((m_mmwp | w[1]) != w[1]) || (rlb_new != w[2]))
            m_ign = 1'b1;
         m_mml  = m_mml | w[0];
         m_mmwp = m_mmwp | w[1];
         m_rlb  = rlb_new;
      end
   endtask

   initial model_reset();

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else if (bus_if.csr_we_i) model_write(bus_if.csr_addr_i, bus_if.csr_wdata_i);
      else m_ign = 1'b0;
   end

   // ---------------- scoreboard: every falling edge ----------------
   always @(negedge clk) begin
      check("rdata", {2'b00, bus_if.csr_rdata_o}, {2'b00, model_read(bus_if.csr_addr_i)});
      check("wr_ignored", {33'd0, bus_if.csr_wr_ignored_o}, {33'd0, m_ign});
      for (int r = 0; r < N; r++) begin
         check($sformatf("cfg_o[%0d]", r), {26'd0, cfg_byte(cfg_o[r])}, {26'd0, m_cfg[r]});
         check($sformatf("addr_o[%0d]", r), addr_o[r], {m_addr[r], 2'b00});
      end
      check("mseccfg_o", {31'd0, msec_o}, {31'd0, m_rlb, m_mmwp, m_mml});
   end

   // ---------------- driver tasks ----------------
   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      @(posedge clk); #2;
      bus_if.csr_we_i    = 1'b1;
      bus_if.csr_addr_i  = a;
      bus_if.csr_wdata_i = d;
      @(posedge clk); #2;
      bus_if.csr_we_i    = 1'b0;
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
      @(posedge clk); #2;
      bus_if.csr_addr_i = a;
      #1;
      check(name, {2'b00, bus_if.csr_rdata_o}, {2'b00, exp});
   endtask

   task automatic ign(input logic exp, input string name);
      check(name, {33'd0, bus_if.csr_wr_ignored_o}, {33'd0, exp});
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      bus_if.csr_we_i    = 1'b0;
      bus_if.csr_addr_i  = 12'h0;
      bus_if.csr_wdata_i = 32'h0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // reset state
      rd(12'h3A0, 32'h0, "rst_cfg0");
      rd(12'h3B0, 32'h0, "rst_addr0");
      check("rst_mode0", {32'd0, cfg_o[0].mode}, 34'd0);
      rd(12'h747, 32'h0, "rst_mseccfg");

      // WARL: W without R dropped, NA4 -> OFF, NAPOT/OFF read-back masking
      wr(12'h3A0, 32'h0000_0002); ign(1'b0, "w_only_ign");
      rd(12'h3A0, 32'h0, "w_only_rd");
      wr(12'h3A0, 32'h0000_1B11); ign(1'b0, "na4_ign");
      rd(12'h3A0, 32'h0000_1B01, "na4_napot_rd");
      check("na4_mode0", {32'd0, cfg_o[0].mode}, 34'd0);
      rd(12'h3B1, 32'h1, "napot_zero_rd");
      wr(12'h3B1, 32'h100);
      rd(12'h3B1, 32'h101, "napot_rd");
      check("napot_raw", addr_o[1], 34'h400);
      wr(12'h3A0, 32'h0000_0001);
      rd(12'h3B1, 32'h100, "off_rd");
      wr(12'h3B1, 32'h103);
      rd(12'h3B1, 32'h100, "off_mask_rd");
      check("off_raw", addr_o[1], 34'h40C);

      // RLB bypass, then lock rlb out
      wr(12'h747, 32'h4); ign(1'b0, "rlb_set_ign");
      rd(12'h747, 32'h4, "rlb_set_rd");
      wr(12'h3A0, 32'h83);
      rd(12'h3A0, 32'h83, "lock0_rd");
      wr(12'h3B0, 32'h55); ign(1'b0, "rlb_addr_ign");
      rd(12'h3B0, 32'h54, "rlb_addr_rd");
      wr(12'h3A0, 32'h01); ign(1'b0, "rlb_cfg_ign");
      rd(12'h3A0, 32'h01, "rlb_cfg_rd");
      wr(12'h3A0, 32'h83);
      wr(12'h747, 32'h0); ign(1'b0, "rlb_clr_ign");
      wr(12'h747, 32'h4); ign(1'b1, "rlb_reset_ign");
      rd(12'h747, 32'h0, "rlb_stuck_rd");

      // lock blocks pmpaddr, pulse lasts one cycle
      wr(12'h3B0, 32'h1234); ign(1'b1, "lock_addr_ign");
      @(posedge clk); #2; ign(1'b0, "lock_addr_ign_end");
      rd(12'h3B0, 32'h54, "lock_addr_rd");

      // TOR lock of region 3 freezes pmpaddr2
      wr(12'h3A0, 32'h8B00_0083); ign(1'b0, "tor_cfg_ign");
      rd(12'h3A0, 32'h8B00_0083, "tor_cfg_rd");
      wr(12'h3B2, 32'h77); ign(1'b1, "tor_addr2_ign");
      rd(12'h3B2, 32'h0, "tor_addr2_rd");
      wr(12'h3B1, 32'h77); ign(1'b0, "addr1_ign");
      rd(12'h3B1, 32'h74, "addr1_rd");
      wr(12'h3B3, 32'h99); ign(1'b1, "addr3_ign");

      // partly / wholly unimplemented registers
      wr(12'h3A1, 32'hFFFF_FFFF); ign(1'b0, "cfg1_ign");
      rd(12'h3A1, 32'h0000_9F9F, "cfg1_rd");
      wr(12'h3A2, 32'h12); ign(1'b0, "cfg2_ign");
      rd(12'h3A2, 32'h0, "cfg2_rd");
      wr(12'h3B6, 32'hAB); ign(1'b0, "addr6_ign");
      rd(12'h3B6, 32'h0, "addr6_rd");
      wr(12'h757, 32'h7); ign(1'b0, "msech_ign");
      rd(12'h757, 32'h0, "msech_rd");
      rd(12'h747, 32'h0, "msec_after_h_rd");

      // asynchronous reset mid-sequence
      @(posedge clk); #3;
      bus_if.csr_addr_i = 12'h3A0;
      rst_n = 1'b0;
      #1;
      check("midrst_cfg0", {26'd0, cfg_byte(cfg_o[0])}, 34'd0);
      check("midrst_rdata", {2'b00, bus_if.csr_rdata_o}, 34'd0);
      @(posedge clk); #2 rst_n = 1'b1;

      // Smepmp MML rules
      wr(12'h747, 32'h1); ign(1'b0, "mml_set_ign");
      rd(12'h747, 32'h1, "mml_set_rd");
      wr(12'h3A0, 32'h84); ign(1'b1, "mml_lx_ign");
      rd(12'h3A0, 32'h0, "mml_lx_rd");
      wr(12'h3A0, 32'h82); ign(1'b1, "mml_lw_ign");
      rd(12'h3A0, 32'h0, "mml_lw_rd");
      wr(12'h3A0, 32'h02); ign(1'b0, "mml_w_ign");
      rd(12'h3A0, 32'h02, "mml_w_rd");
      wr(12'h3A1, 32'h83); ign(1'b0, "mml_lrw_ign");
      rd(12'h3A1, 32'h83, "mml_lrw_rd");
      wr(12'h747, 32'h0); ign(1'b1, "mml_sticky_ign");
      rd(12'h747, 32'h1, "mml_sticky_rd");
      wr(12'h747, 32'h3); ign(1'b0, "mmwp_ign");
      rd(12'h747, 32'h3, "mmwp_rd");

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
